// File: rtl/stream_ser.sv
// Word-to-beat serializer: splits an N*W-bit word into up to N W-bit beats.
// One output register plus one holding register; beat 0 bypasses the holder when the output slot is free.
module stream_ser #(
    parameter int W = 32,
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A__in_vld,
    input  logic [N*W-1:0]   A__in_w,
    input  logic [$clog2(N)-1:0] A__in_len,
    output logic             A__stall_r,
    output logic             B__out_vld_r,
    output logic [W-1:0]     B__out_r,
    output logic             B__out_last_r,
    input  logic             B__stall
);
    localparam int LW = $clog2(N);

    logic           hold_vld_r;
    logic [N*W-1:0] hold_w_r;
    logic [LW-1:0]  hold_len_r;
    logic [LW-1:0]  idx_r;
    logic           slot_free;
    logic [W-1:0]   hold_beat;

    // Backpressure is exactly the holding-register occupancy, so it never depends on inputs.
    assign A__stall_r = hold_vld_r;
    assign slot_free  = !B__out_vld_r || !B__stall;

    always_comb begin
        hold_beat = hold_w_r[W-1:0];
        for (int k = 0; k < N; k++) begin
            if (idx_r == LW'(k)) begin
                hold_beat = hold_w_r[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld_r    <= 1'b0;
            idx_r         <= '0;
            B__out_vld_r  <= 1'b0;
            B__out_last_r <= 1'b0;
        end else if (hold_vld_r) begin
            // Drain the held word; freeing the holder on its last beat lets upstream resume next cycle.
            if (slot_free) begin
                B__out_vld_r  <= 1'b1;
                B__out_r      <= hold_beat;
                B__out_last_r <= (idx_r == hold_len_r);
                idx_r         <= idx_r + 1'b1;
                if (idx_r == hold_len_r) begin
                    hold_vld_r <= 1'b0;
                end
            end
        end else if (A__in_vld) begin
            if (slot_free) begin
                B__out_vld_r  <= 1'b1;
                B__out_r      <= A__in_w[W-1:0];
                B__out_last_r <= (A__in_len == '0);
                if (A__in_len != '0) begin
                    hold_w_r   <= A__in_w;
                    hold_len_r <= A__in_len;
                    idx_r      <= LW'(1);
                    hold_vld_r <= 1'b1;
                end
            end else begin
                hold_w_r   <= A__in_w;
                hold_len_r <= A__in_len;
                idx_r      <= '0;
                hold_vld_r <= 1'b1;
            end
        end else if (slot_free) begin
            B__out_vld_r  <= 1'b0;
            B__out_last_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stream_ser.sv
// Directed and randomized checks of stream_ser (W=8, N=4) against a beat-queue reference model.
module tb_stream_ser;
    localparam int W = 8;
    localparam int N = 4;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_vld = 1'b0;
    logic [N*W-1:0] in_w = '0;
    logic [1:0]     in_len = '0;
    logic           stall_r;
    logic           out_vld_r;
    logic [W-1:0]   out_r;
    logic           out_last_r;
    logic           b_stall = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: output slot plus a queue of beats still waiting in the holder.
    logic         m_out_vld = 1'b0;
    logic [W-1:0] m_out     = '0;
    logic         m_last    = 1'b0;
    beat_t        m_hold_q[$];

    logic         watch_en = 1'b0;
    logic [W-1:0] forbid_a = '0;
    logic [W-1:0] forbid_b = '0;
    logic         seen_forbid = 1'b0;

    stream_ser #(.W(W), .N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .A__in_vld    (in_vld),
        .A__in_w      (in_w),
        .A__in_len    (in_len),
        .A__stall_r   (stall_r),
        .B__out_vld_r (out_vld_r),
        .B__out_r     (out_r),
        .B__out_last_r(out_last_r),
        .B__stall     (b_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        beat_t b;
        beat_t beats[$];
        logic  free;
        if (rst) begin
            m_out_vld = 1'b0;
            m_last    = 1'b0;
            m_hold_q.delete();
        end else begin
            free = !m_out_vld || !b_stall;
            if (m_hold_q.size() != 0) begin
                if (free) begin
                    b = m_hold_q.pop_front();
                    m_out_vld = 1'b1;
                    m_out     = b.data;
                    m_last    = b.last;
                end
            end else if (in_vld) begin
                for (int k = 0; k <= int'(in_len); k++) begin
                    b.data = in_w[k*W +: W];
                    b.last = (k == int'(in_len));
                    beats.push_back(b);
                end
                if (free) begin
                    b = beats.pop_front();
                    m_out_vld = 1'b1;
                    m_out     = b.data;
                    m_last    = b.last;
                end
                foreach (beats[i]) m_hold_q.push_back(beats[i]);
            end else if (free) begin
                m_out_vld = 1'b0;
            end
        end
    endtask

    // One clock: advance the model on current inputs, take the edge, compare every output.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("out_vld", out_vld_r, m_out_vld);
        chk("stall_r", stall_r, (m_hold_q.size() != 0));
        if (m_out_vld) begin
            chk("out_data", out_r, m_out);
            chk("out_last", out_last_r, m_last);
        end
        if (watch_en && out_vld_r && (out_r == forbid_a || out_r == forbid_b)) seen_forbid = 1'b1;
    endtask

    task automatic expect_beat(input string tag, input logic [W-1:0] d, input logic l, input logic s);
        chk({tag, "_vld"}, out_vld_r, 1'b1);
        chk({tag, "_data"}, out_r, d);
        chk({tag, "_last"}, out_last_r, l);
        chk({tag, "_stall"}, stall_r, s);
    endtask

    task automatic present(input logic [N*W-1:0] w, input logic [1:0] len);
        in_vld = 1'b1;
        in_w   = w;
        in_len = len;
    endtask

    task automatic drain();
        in_vld  = 1'b0;
        b_stall = 1'b0;
        for (int i = 0; i < 20 && (stall_r || out_vld_r); i++) cycle();
        chk("drain_bound", {stall_r, out_vld_r}, 2'b00);
    endtask

    initial begin
        rst = 1'b1;
        cycle();
        cycle();
        chk("reset_vld", out_vld_r, 1'b0);
        chk("reset_stall", stall_r, 1'b0);
        rst = 1'b0;
        cycle();

        // Single four-beat word, no backpressure.
        present(32'h44332211, 2'd3);
        cycle();
        in_vld = 1'b0;
        expect_beat("w1_b0", 8'h11, 1'b0, 1'b1);
        cycle(); expect_beat("w1_b1", 8'h22, 1'b0, 1'b1);
        cycle(); expect_beat("w1_b2", 8'h33, 1'b0, 1'b1);
        cycle(); expect_beat("w1_b3", 8'h44, 1'b1, 1'b0);
        cycle();
        chk("w1_idle", out_vld_r, 1'b0);

        // Two len=1 words back to back; second held until the holder frees.
        present(32'h00002211, 2'd1);
        cycle(); expect_beat("w2_b0", 8'h11, 1'b0, 1'b1);
        present(32'h00004433, 2'd1);
        cycle(); expect_beat("w2_b1", 8'h22, 1'b1, 1'b0);
        cycle(); expect_beat("w3_b0", 8'h33, 1'b0, 1'b1);
        in_vld = 1'b0;
        cycle(); expect_beat("w3_b1", 8'h44, 1'b1, 1'b0);
        drain();

        // Single-beat words every cycle.
        present(32'h000000A0, 2'd0); cycle(); expect_beat("s0", 8'hA0, 1'b1, 1'b0);
        present(32'h000000A1, 2'd0); cycle(); expect_beat("s1", 8'hA1, 1'b1, 1'b0);
        present(32'h000000A2, 2'd0); cycle(); expect_beat("s2", 8'hA2, 1'b1, 1'b0);
        in_vld = 1'b0;
        drain();

        // Downstream stall holds 0x11 while a new word lands in the holder.
        present(32'h00000011, 2'd0);
        cycle(); expect_beat("st_b", 8'h11, 1'b1, 1'b0);
        b_stall = 1'b1;
        present(32'h88776655, 2'd3);
        cycle(); expect_beat("st_h0", 8'h11, 1'b1, 1'b1);
        in_vld = 1'b0;
        cycle(); expect_beat("st_h1", 8'h11, 1'b1, 1'b1);
        cycle(); expect_beat("st_h2", 8'h11, 1'b1, 1'b1);
        b_stall = 1'b0;
        cycle(); expect_beat("st_r0", 8'h55, 1'b0, 1'b1);
        cycle(); expect_beat("st_r1", 8'h66, 1'b0, 1'b1);
        cycle(); expect_beat("st_r2", 8'h77, 1'b0, 1'b1);
        cycle(); expect_beat("st_r3", 8'h88, 1'b1, 1'b0);
        drain();

        // Reset mid-word, with a word offered during reset.
        watch_en = 1'b1; forbid_a = 8'h33; forbid_b = 8'h44; seen_forbid = 1'b0;
        present(32'h44332211, 2'd3);
        cycle(); in_vld = 1'b0;
        cycle(); expect_beat("rs_b1", 8'h22, 1'b0, 1'b1);
        rst = 1'b1;
        present(32'h000000FF, 2'd0);
        cycle();
        rst = 1'b0; in_vld = 1'b0;
        chk("rs_vld", out_vld_r, 1'b0);
        chk("rs_stall", stall_r, 1'b0);
        repeat (5) cycle();
        chk("rs_no_stale", seen_forbid, 1'b0);

        // Word offered while stalled is dropped.
        forbid_a = 8'hFF; forbid_b = 8'hFF; seen_forbid = 1'b0;
        present(32'h44332211, 2'd3);
        cycle();
        present(32'h000000FF, 2'd0);
        cycle();
        cycle();
        in_vld = 1'b0;
        drain();
        chk("drop_ff", seen_forbid, 1'b0);
        watch_en = 1'b0;

        // Random traffic with random backpressure and rare resets.
        for (int i = 0; i < 400; i++) begin
            in_vld  = ($urandom_range(0, 3) != 0);
            in_w    = $urandom;
            in_len  = 2'($urandom_range(0, 3));
            b_stall = ($urandom_range(0, 3) == 0);
            rst     = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
